// File: rtl/poly_cmd_scheduler.sv
// poly_cmd_scheduler: queues 35-bit multiplier commands in a small FIFO and issues them one at
// a time to the polynomial multiplier. While a command runs, the shared BRAM port is handed to
// the multiplier. While the scheduler is idle, the host owns the port.
//
// Optional feature: define SCHED_WATCHDOG_EN to enable a WAIT-state watchdog of WDOG_CYCLES.
// The watchdog flags err_flags[3], pulses mult_rst and abandons the command.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   command_in, command_we    command word {op[2:0], mode[1:0], a[9:0], b[9:0], w[9:0]} and push
//   cmd_full                  FIFO full
//   mult_start, mult_rst      start pulse and reset for the multiplier
//   mult_mode, mult_*_base    latched fields of the last issued MUL
//   mult_done                 multiplier completion (level or pulse)
//   wea_ext, ext_wea_gated    host BRAM write request and its gated version
//   bram_sel                  0 = host owns the BRAM port, 1 = multiplier owns it
//   busy                      scheduler active or commands pending
//   done_ins_computation      one-cycle pulse per completed instruction
//   err_flags                 sticky {timeout, host conflict, illegal op, overflow}
module poly_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [34:0]       command_in,
  input  logic              command_we,
  output logic              cmd_full,
  output logic              mult_start,
  output logic              mult_rst,
  output logic [1:0]        mult_mode,
  output logic [ADDR_W-1:0] mult_op_a_base,
  output logic [ADDR_W-1:0] mult_op_b_base,
  output logic [ADDR_W-1:0] mult_write_base,
  input  logic              mult_done,
  input  logic              wea_ext,
  output logic              bram_sel,
  output logic              ext_wea_gated,
  output logic              busy,
  output logic              done_ins_computation,
  output logic [3:0]        err_flags
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] OpNop = 3'd0;
  localparam logic [2:0] OpMul = 3'd1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state;
  logic [34:0]     fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic [34:0]     head;
  logic            push;
  logic            pop;
  logic [2:0]      err_q;
  logic            err_timeout;
  logic            wdog_fire;
  logic            wdog_rst_q;

  assign head     = fifo_mem[rd_ptr];
  assign cmd_full = (count == CntW'(FIFO_DEPTH));
  // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
  assign push     = command_we && !cmd_full;
  assign pop      = (state == StIdle) && (count != '0);

  assign busy          = (state != StIdle) || (count != '0);
  assign ext_wea_gated = wea_ext && !bram_sel;
  assign mult_rst      = rst || wdog_rst_q;
  assign err_flags     = {err_timeout, err_q};

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= command_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= StIdle;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      count                <= '0;
      mult_start           <= 1'b0;
      mult_mode            <= '0;
      mult_op_a_base       <= '0;
      mult_op_b_base       <= '0;
      mult_write_base      <= '0;
      bram_sel             <= 1'b0;
      done_ins_computation <= 1'b0;
      err_q                <= '0;
    end else begin
      mult_start           <= 1'b0;
      done_ins_computation <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CntW'(push) - CntW'(pop);

      if (command_we && cmd_full) begin
        err_q[0] <= 1'b1;
      end
      if (wea_ext && bram_sel) begin
        err_q[2] <= 1'b1;
      end

      case (state)
        StIdle: begin
          if (pop) begin
            case (head[34:32])
              OpMul: begin
                mult_mode       <= head[31:30];
                mult_op_a_base  <= ADDR_W'(head[29:20]);
                mult_op_b_base  <= ADDR_W'(head[19:10]);
                mult_write_base <= ADDR_W'(head[9:0]);
                mult_start      <= 1'b1;
                bram_sel        <= 1'b1;
                state           <= StIssue;
              end
              OpNop: begin
                done_ins_computation <= 1'b1;
                state                <= StDone;
              end
              default: begin
                err_q[1] <= 1'b1;
              end
            endcase
          end
        end
        StIssue: begin
          state <= StWait;
        end
        StWait: begin
          if (mult_done) begin
            bram_sel             <= 1'b0;
            done_ins_computation <= 1'b1;
            state                <= StDone;
          end else if (wdog_fire) begin
            bram_sel <= 1'b0;
            state    <= StIdle;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

  logic [WdogW-1:0] wdog_cnt;

  // Counter is cleared on every cycle outside WAIT, so it starts at zero on WAIT entry.
  assign wdog_fire = (state == StWait) && !mult_done &&
                     (wdog_cnt == WdogW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt    <= '0;
      err_timeout <= 1'b0;
      wdog_rst_q  <= 1'b0;
    end else begin
      wdog_rst_q <= wdog_fire;
      if (state != StWait) begin
        wdog_cnt <= '0;
      end else begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_fire) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  assign wdog_fire   = 1'b0;
  assign err_timeout = 1'b0;
  assign wdog_rst_q  = 1'b0;
`endif

endmodule

// File: tb/tb_poly_cmd_scheduler.sv
// Scoreboard bench for poly_cmd_scheduler. Expected multiplier fields are queued when a command
// is pushed. A negedge monitor pops them on every mult_start and done_ins_computation.
module tb_poly_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [34:0] command_in = '0;
  logic        command_we = 1'b0;
  logic        cmd_full;
  logic        mult_start;
  logic        mult_rst;
  logic [1:0]  mult_mode;
  logic [9:0]  mult_op_a_base;
  logic [9:0]  mult_op_b_base;
  logic [9:0]  mult_write_base;
  logic        mult_done = 1'b0;
  logic        wea_ext = 1'b0;
  logic        bram_sel;
  logic        ext_wea_gated;
  logic        busy;
  logic        done_ins_computation;
  logic [3:0]  err_flags;

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int n_done = 0;

  logic [31:0] exp_mul[$];
  logic [31:0] exp_done[$];
  logic [31:0] last_mul = '0;

  always #5 clk = ~clk;

  poly_cmd_scheduler #(
    .FIFO_DEPTH (4),
    .ADDR_W     (10),
    .WDOG_CYCLES(16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .command_in          (command_in),
    .command_we          (command_we),
    .cmd_full            (cmd_full),
    .mult_start          (mult_start),
    .mult_rst            (mult_rst),
    .mult_mode           (mult_mode),
    .mult_op_a_base      (mult_op_a_base),
    .mult_op_b_base      (mult_op_b_base),
    .mult_write_base     (mult_write_base),
    .mult_done           (mult_done),
    .wea_ext             (wea_ext),
    .bram_sel            (bram_sel),
    .ext_wea_gated       (ext_wea_gated),
    .busy                (busy),
    .done_ins_computation(done_ins_computation),
    .err_flags           (err_flags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one push cycle; drop marks a push the DUT must discard.
  task automatic push_cmd(input logic [34:0] c, input bit drop);
    command_in = c;
    command_we = 1'b1;
    if (!drop) begin
      if (c[34:32] == 3'd1) begin
        exp_mul.push_back(c[31:0]);
        exp_done.push_back(c[31:0]);
        last_mul = c[31:0];
      end else if (c[34:32] == 3'd0) begin
        exp_done.push_back(last_mul);
      end
    end
    tick();
    command_we = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int cyc);
    cyc = 0;
    while (!mult_start && cyc < 50) begin
      tick();
      cyc++;
    end
    check(tag, mult_start, 1'b1);
  endtask

  task automatic pulse_done();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
  endtask

  task automatic model_reset();
    exp_mul.delete();
    exp_done.delete();
    last_mul = '0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mult_start) begin
        n_start++;
        check("start_bram_sel", bram_sel, 1'b1);
        if (exp_mul.size() == 0) begin
          check("start_unexpected", 0, 1);
        end else begin
          check("start_fields", {mult_mode, mult_op_a_base, mult_op_b_base, mult_write_base},
                exp_mul.pop_front());
        end
      end
      if (done_ins_computation) begin
        n_done++;
        check("done_bram_sel", bram_sel, 1'b0);
        if (exp_done.size() == 0) begin
          check("done_unexpected", 0, 1);
        end else begin
          check("done_fields", {mult_mode, mult_op_a_base, mult_op_b_base, mult_write_base},
                exp_done.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc;
    int sel_bad;
    int s0;
    int d0;

    // 1: reset
    repeat (3) tick();
    check("rst_mult_rst", mult_rst, 1'b1);
    check("rst_outputs", {mult_start, bram_sel, ext_wea_gated, done_ins_computation, busy,
                          cmd_full}, 6'b0);
    check("rst_err", err_flags, 4'h0);
    check("rst_fields", {mult_mode, mult_op_a_base, mult_op_b_base, mult_write_base}, 32'h0);
    rst = 1'b0;
    tick();
    check("rst_release_mult_rst", mult_rst, 1'b0);

    // 2: single MUL, done 20 cycles after start
    s0 = n_start;
    d0 = n_done;
    push_cmd({3'd1, 2'd2, 10'd0, 10'd256, 10'd512}, 1'b0);
    check("t2_busy_queued", busy, 1'b1);
    wait_start("t2_start", cyc);
    check("t2_latency", cyc, 1);
    sel_bad = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (!bram_sel || mult_start) sel_bad++;
    end
    check("t2_sel_hold", sel_bad, 0);
    pulse_done();
    check("t2_done_pulse", done_ins_computation, 1'b1);
    tick();
    check("t2_done_width", done_ins_computation, 1'b0);
    check("t2_idle", busy, 1'b0);
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    tick();
    check("t2_done_ignored_idle", n_done - d0, 1);
    check("t2_starts", n_start - s0, 1);

    // 3: overflow with multiplier stalled
    s0 = n_start;
    d0 = n_done;
    check("t3_err_clear", err_flags[0], 1'b0);
    push_cmd({3'd1, 2'd1, 10'd1, 10'd2, 10'd3}, 1'b0);
    wait_start("t3_start0", cyc);
    tick();
    for (int i = 0; i < 5; i++) begin
      push_cmd({3'd1, 2'(i), 10'(16 * i + 16), 10'(16 * i + 17), 10'(16 * i + 18)}, i == 4);
    end
    check("t3_full", cmd_full, 1'b1);
    check("t3_err_ovf", err_flags[0], 1'b1);
    pulse_done();
    tick();
    push_cmd({3'd1, 2'd3, 10'd999, 10'd998, 10'd997}, 1'b1);
    check("t3_full_after_pop", cmd_full, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_start("t3_start_q", cyc);
      repeat (3) tick();
      pulse_done();
    end
    tick();
    tick();
    check("t3_dones", n_done - d0, 5);
    check("t3_starts", n_start - s0, 5);
    check("t3_idle", busy, 1'b0);

    // 4: NOP, illegal, MUL
    s0 = n_start;
    d0 = n_done;
    check("t4_err_clear", err_flags[1], 1'b0);
    push_cmd({3'd0, 32'h0}, 1'b0);
    push_cmd({3'd5, 2'd1, 10'd7, 10'd7, 10'd7}, 1'b0);
    push_cmd({3'd1, 2'd0, 10'd100, 10'd200, 10'd300}, 1'b0);
    wait_start("t4_start", cyc);
    check("t4_err_illegal", err_flags[1], 1'b1);
    repeat (4) tick();
    pulse_done();
    tick();
    tick();
    check("t4_dones", n_done - d0, 2);
    check("t4_starts", n_start - s0, 1);

    // 5: host conflict
    check("t5_err_clear", err_flags[2], 1'b0);
    push_cmd({3'd1, 2'd3, 10'd11, 10'd22, 10'd33}, 1'b0);
    wait_start("t5_start", cyc);
    tick();
    wea_ext = 1'b1;
    #1;
    check("t5_gate_busy", ext_wea_gated, 1'b0);
    tick();
    wea_ext = 1'b0;
    check("t5_err_conflict", err_flags[2], 1'b1);
    pulse_done();
    tick();
    wea_ext = 1'b1;
    #1;
    check("t5_gate_idle", ext_wea_gated, 1'b1);
    tick();
    wea_ext = 1'b0;

    // 6: rst mid-WAIT aborts without a done pulse and empties the FIFO
    s0 = n_start;
    d0 = n_done;
    push_cmd({3'd1, 2'd1, 10'd5, 10'd6, 10'd7}, 1'b0);
    push_cmd({3'd0, 32'h0}, 1'b0);
    wait_start("t6_start", cyc);
    repeat (3) tick();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    check("t6_after_rst", {busy, cmd_full, bram_sel, done_ins_computation}, 4'b0);
    check("t6_err_cleared", err_flags, 4'h0);
    repeat (5) tick();
    check("t6_no_done", n_done - d0, 0);
    check("t6_no_restart", n_start - s0, 1);
    check("t6_still_idle", busy, 1'b0);

`ifdef SCHED_WATCHDOG_EN
    // 7: watchdog expiry after 16 WAIT cycles
    d0 = n_done;
    push_cmd({3'd1, 2'd2, 10'd40, 10'd41, 10'd42}, 1'b0);
    wait_start("t7_start", cyc);
    tick();
    repeat (15) tick();
    check("t7_not_yet", err_flags[3], 1'b0);
    tick();
    void'(exp_done.pop_back());
    check("t7_err_timeout", err_flags[3], 1'b1);
    check("t7_mult_rst", mult_rst, 1'b1);
    check("t7_idle", {busy, bram_sel}, 2'b0);
    tick();
    check("t7_mult_rst_pulse", mult_rst, 1'b0);
    push_cmd({3'd0, 32'h0}, 1'b0);
    repeat (3) tick();
    check("t7_continue", n_done - d0, 1);
`else
    check("t6_no_timeout_flag", err_flags[3], 1'b0);
`endif

    check("sb_mul_empty", exp_mul.size(), 0);
    check("sb_done_empty", exp_done.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
